// File: rtl/acc_mem_reader.sv
// acc_mem_reader: drains the accumulator memory in address order onto a
// valid/ready stream. Each word can optionally be zeroed after it is read.
// The top-level mux gives this block the memory port only while busy=1.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; done is cleared here, so it is a 1-cycle pulse
// CAPTURE | read data is valid; register it onto the stream and issue a clear
// PRESENT | hold the word until it is handshaken, then step to the next address
// DONE    | raise done, drop busy, then return to IDLE
module acc_mem_reader #(
  parameter int WORD_WIDTH = 32,
  parameter int MEM_SIZE   = 553,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear_en,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] acc_mem_addr_o,
  input  logic [WORD_WIDTH-1:0] acc_mem_data_i,
  output logic                  acc_mem_write_en,
  output logic [WORD_WIDTH-1:0] acc_mem_write_data_o,
  output logic [WORD_WIDTH-1:0] m_data_o,
  output logic [ADDR_WIDTH-1:0] m_index_o,
  output logic                  m_last_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    PRESENT,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  clr;

  // Drain sequencer: all outputs are registered here. A non-IDLE abort
  // overrides every other transition; the write strobe issued on the abort
  // edge has already been seen by the memory, so only later writes are
  // suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      idx                  <= '0;
      clr                  <= 1'b0;
      acc_mem_addr_o       <= '0;
      acc_mem_write_en     <= 1'b0;
      acc_mem_write_data_o <= '0;
      m_data_o             <= '0;
      m_index_o            <= '0;
      m_last_o             <= 1'b0;
      m_valid_o            <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else if (abort && state != IDLE) begin
      m_valid_o        <= 1'b0;
      acc_mem_write_en <= 1'b0;
      busy             <= 1'b0;
      state            <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            acc_mem_addr_o <= '0;
            idx            <= '0;
            clr            <= clear_en;
            busy           <= 1'b1;
            state          <= CAPTURE;
          end
        end
        CAPTURE: begin
          m_data_o  <= acc_mem_data_i;
          m_index_o <= idx;
          m_last_o  <= (idx == LAST_IDX);
          m_valid_o <= 1'b1;
          // Address is left alone so the zero overwrites the word just read.
          if (clr) begin
            acc_mem_write_en     <= 1'b1;
            acc_mem_write_data_o <= '0;
          end
          state <= PRESENT;
        end
        PRESENT: begin
          acc_mem_write_en <= 1'b0;
          if (m_valid_o && m_ready_i) begin
            m_valid_o <= 1'b0;
            if (m_last_o) begin
              state <= DONE;
            end else begin
              idx            <= idx + ADDR_WIDTH'(1);
              acc_mem_addr_o <= idx + ADDR_WIDTH'(1);
              state          <= CAPTURE;
            end
          end
        end
        DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          m_last_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_mem_reader.sv
// Bench for acc_mem_reader: behavioural accumulator memory plus a queue of
// expected stream words that are compared while each word is presented.
module tb_acc_mem_reader;
  localparam int WW = 32;
  localparam int MS = 553;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          clear_en = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] addr, m_index;
  logic [WW-1:0] rdata, wdata, m_data;
  logic          we, m_last, m_valid, busy, done;

  acc_mem_reader #(.WORD_WIDTH(WW), .MEM_SIZE(MS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en), .abort(abort),
    .acc_mem_addr_o(addr), .acc_mem_data_i(rdata), .acc_mem_write_en(we),
    .acc_mem_write_data_o(wdata), .m_data_o(m_data), .m_index_o(m_index),
    .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [MS];
  int            wr_count [MS];
  logic          load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < MS; i++) begin
        mem[i]      <= WW'(i * 3 + 1);
        wr_count[i] <= 0;
      end
    end else if (we && int'(addr) < MS) begin
      mem[addr]      <= wdata;
      wr_count[addr] <= wr_count[addr] + 1;
    end
  end

  assign rdata = (int'(addr) < MS) ? mem[addr] : '0;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   passed = 0;
  int   total = 0;
  int   cyc;

  task automatic load;
    @(negedge clk) load_mem = 1'b1;
    @(negedge clk) load_mem = 1'b0;
  endtask

  // Words up to zeroed_upto are expected to read as zero.
  task automatic push_expected(input int zeroed_upto);
    for (int i = 0; i < MS; i++) begin
      e.data = (i <= zeroed_upto) ? '0 : WW'(i * 3 + 1);
      e.idx  = AW'(i);
      e.last = (i == MS - 1);
      q.push_back(e);
    end
  endtask

  // Returns at the negedge just after the edge that accepted start (cyc 0).
  task automatic pulse_start(input logic ce);
    @(negedge clk);
    start    = 1'b1;
    clear_en = ce;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({addr, we, wdata, m_data, m_index, m_last, m_valid, busy, done} !== '0)
      $display("FAIL reset_outputs: got busy=%b valid=%b addr=%0d data=%0h", busy, m_valid, addr, m_data);
    else passed++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, m_valid, done, we} !== 4'b0)
      $display("FAIL idle_after_reset: got busy=%b valid=%b done=%b we=%b required 0", busy, m_valid, done, we);
    else passed++;
  endtask

  task automatic test_drain;
    int done_cnt = 0, done_at = -1, first_valid = -1, bad = 0, wsum = 0;
    bit restart_sent = 0;
    load();
    push_expected(-1);
    pulse_start(1'b0);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b required 1", busy);
    else passed++;
    m_ready = 1'b1;
    while (cyc < 1200) begin
      start = 1'b0;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_index == AW'(50) && !restart_sent) begin
        start = 1'b1;
        restart_sent = 1;
      end
      if (m_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL drain_extra_word: got index %0d required none", m_index);
        else begin
          e = q[0];
          if ({m_data, m_index, m_last} !== e)
            $display("FAIL drain_word: got %0h/%0d/%b required %0h/%0d/%b", m_data, m_index, m_last, e.data, e.idx, e.last);
          else passed++;
          if (m_ready) void'(q.pop_front());
        end
      end
      if (done) begin done_cnt++; done_at = cyc; end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    for (int i = 0; i < MS; i++) begin
      if (mem[i] !== WW'(i * 3 + 1)) bad++;
      wsum += wr_count[i];
    end
    total++;
    if (first_valid != 1) $display("FAIL first_valid_cycle: got %0d required 1", first_valid);
    else passed++;
    total++;
    if (done_at != 2 * MS + 1) $display("FAIL done_cycle: got %0d required %0d", done_at, 2 * MS + 1);
    else passed++;
    total++;
    if (done_cnt != 1) $display("FAIL done_count: got %0d required 1", done_cnt);
    else passed++;
    total++;
    if (q.size() != 0) $display("FAIL drain_missing: got %0d words left required 0", q.size());
    else passed++;
    total++;
    if (bad != 0 || wsum != 0) $display("FAIL mem_unchanged: got %0d changed, %0d writes required 0", bad, wsum);
    else passed++;
    q.delete();
  endtask

  task automatic test_clear_drain;
    int done_cnt = 0, done_at = -1, bad = 0, we_cycles = 0;
    load();
    push_expected(-1);
    pulse_start(1'b1);
    clear_en = 1'b0;
    m_ready  = 1'b1;
    while (cyc < 1200) begin
      if (we) we_cycles++;
      if (m_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL clear_extra_word: got index %0d required none", m_index);
        else begin
          e = q[0];
          if ({m_data, m_index, m_last} !== e)
            $display("FAIL clear_word: got %0h/%0d/%b required %0h/%0d/%b", m_data, m_index, m_last, e.data, e.idx, e.last);
          else passed++;
          if (m_ready) void'(q.pop_front());
        end
      end
      if (done) begin done_cnt++; done_at = cyc; end
      @(negedge clk); cyc++;
    end
    for (int i = 0; i < MS; i++) if (mem[i] !== '0 || wr_count[i] != 1) bad++;
    total++;
    if (done_at != 2 * MS + 1 || done_cnt != 1)
      $display("FAIL clear_done: got cycle %0d count %0d required %0d/1", done_at, done_cnt, 2 * MS + 1);
    else passed++;
    total++;
    if (q.size() != 0) $display("FAIL clear_missing: got %0d words left required 0", q.size());
    else passed++;
    total++;
    if (bad != 0) $display("FAIL clear_mem_zero: got %0d bad words required 0", bad);
    else passed++;
    total++;
    if (we_cycles != MS) $display("FAIL clear_we_cycles: got %0d required %0d", we_cycles, MS);
    else passed++;
    q.delete();
  endtask

  task automatic test_stall;
    int done_cnt = 0, done_at = -1, bad = 0, we_cycles = 0, stall_left = 5;
    load();
    push_expected(-1);
    pulse_start(1'b1);
    while (cyc < 4000 && !(done_at >= 0 && cyc > done_at + 3)) begin
      if (m_valid && m_index == AW'(10) && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      if (we) we_cycles++;
      if (m_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL stall_extra_word: got index %0d required none", m_index);
        else begin
          e = q[0];
          if ({m_data, m_index, m_last} !== e)
            $display("FAIL stall_word: got %0h/%0d/%b required %0h/%0d/%b", m_data, m_index, m_last, e.data, e.idx, e.last);
          else passed++;
          if (m_ready) void'(q.pop_front());
        end
      end
      if (done) begin done_cnt++; done_at = cyc; end
      @(negedge clk); cyc++;
    end
    m_ready = 1'b1;
    for (int i = 0; i < MS; i++) if (mem[i] !== '0 || wr_count[i] != 1) bad++;
    total++;
    if (done_cnt != 1 || stall_left != 0)
      $display("FAIL stall_done: got done count %0d stall left %0d required 1/0", done_cnt, stall_left);
    else passed++;
    total++;
    if (q.size() != 0) $display("FAIL stall_missing: got %0d words left required 0", q.size());
    else passed++;
    total++;
    if (bad != 0 || we_cycles != MS)
      $display("FAIL stall_writes: got %0d bad words, %0d we cycles required 0/%0d", bad, we_cycles, MS);
    else passed++;
    q.delete();
  endtask

  task automatic test_abort;
    int done_cnt = 0, bad = 0;
    bit aborted = 0;
    load();
    push_expected(-1);
    pulse_start(1'b1);
    m_ready = 1'b1;
    while (cyc < 400 && !aborted) begin
      if (m_valid && m_index == AW'(100)) begin
        m_ready = 1'b0;
        abort   = 1'b1;
        aborted = 1;
      end
      if (m_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL abort_extra_word: got index %0d required none", m_index);
        else begin
          e = q[0];
          if ({m_data, m_index, m_last} !== e)
            $display("FAIL abort_word: got %0h/%0d/%b required %0h/%0d/%b", m_data, m_index, m_last, e.data, e.idx, e.last);
          else passed++;
          if (m_ready) void'(q.pop_front());
        end
      end
      @(negedge clk); cyc++;
    end
    abort = 1'b0;
    total++;
    if (!aborted || m_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL abort_response: got seen=%0d valid=%b busy=%b required 1/0/0", aborted, m_valid, busy);
    else passed++;
    repeat (20) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    for (int i = 0; i < MS; i++) begin
      if (i <= 100 && (mem[i] !== '0 || wr_count[i] != 1)) bad++;
      if (i > 100 && (mem[i] !== WW'(i * 3 + 1) || wr_count[i] != 0)) bad++;
    end
    total++;
    if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses required 0", done_cnt);
    else passed++;
    total++;
    if (bad != 0) $display("FAIL abort_mem: got %0d bad words required 0", bad);
    else passed++;
    q.delete();

    // start and abort together in IDLE: the drain must not begin
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL idle_abort_wins: got busy=%b valid=%b required 0/0", busy, m_valid);
    else passed++;

    // restart after abort streams from index 0 with the partly cleared contents
    done_cnt = 0;
    push_expected(100);
    pulse_start(1'b0);
    m_ready = 1'b1;
    while (cyc < 1200) begin
      if (m_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL restart_extra_word: got index %0d required none", m_index);
        else begin
          e = q[0];
          if ({m_data, m_index, m_last} !== e)
            $display("FAIL restart_word: got %0h/%0d/%b required %0h/%0d/%b", m_data, m_index, m_last, e.data, e.idx, e.last);
          else passed++;
          if (m_ready) void'(q.pop_front());
        end
      end
      if (done) done_cnt++;
      @(negedge clk); cyc++;
    end
    total++;
    if (done_cnt != 1 || q.size() != 0)
      $display("FAIL restart_complete: got done %0d, %0d words left required 1/0", done_cnt, q.size());
    else passed++;
    q.delete();
  endtask

  task automatic test_reset_mid;
    bit seen_we = 0;
    load();
    pulse_start(1'b1);
    m_ready = 1'b0;
    while (cyc < 20 && !seen_we) begin
      if (we) seen_we = 1;
      else begin
        @(negedge clk); cyc++;
      end
    end
    total++;
    if (!seen_we) $display("FAIL reset_mid_we_seen: got 0 required 1");
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({addr, we, wdata, m_data, m_index, m_last, m_valid, busy, done} !== '0)
      $display("FAIL reset_mid_async: got we=%b valid=%b busy=%b data=%0h required all 0", we, m_valid, busy, m_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({busy, m_valid, done, we} !== 4'b0)
      $display("FAIL reset_mid_idle: got busy=%b valid=%b done=%b we=%b required 0", busy, m_valid, done, we);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_drain();
    test_clear_drain();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
